// File: rtl/resp_router_l2.sv
// Response router for one L2 bank: tracks outstanding request IDs in order and
// steers each bank response back to its originating master as a one-hot pulse.
module resp_router_l2 #(
    parameter int N_MASTER        = 16,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic                  data_wen_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic                  data_gnt_i,
    output logic                  data_gnt_o,
    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    output logic [N_MASTER-1:0]   data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_wen_o,
    output logic                  err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENT_W = ID_WIDTH + 1;
    localparam logic [31:0] N_MASTER_U = N_MASTER;

    logic [ENT_W-1:0]    fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wptr_reg, wptr_next;
    logic [PTR_W-1:0]    rptr_reg, rptr_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                full, empty, push, pop, pop_ok;
    logic [ID_WIDTH-1:0] pop_id;
    logic                pop_wen;
    logic [31:0]         pop_id_ext;
    logic [N_MASTER-1:0] valid_next;
    logic                err_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign empty      = (count_reg == '0);
    // Full blocks the grant even if a pop frees a slot this cycle: no bypass.
    assign data_gnt_o = data_gnt_i & ~full;
    assign push       = data_req_i & data_gnt_o;
    assign pop        = data_r_valid_i & ~empty;

    assign {pop_id, pop_wen} = fifo_mem[rptr_reg];
    assign pop_id_ext        = 32'(pop_id);
    assign pop_ok            = pop & (pop_id_ext < N_MASTER_U);

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_onehot
            assign valid_next[gi] = pop_ok & (pop_id_ext == 32'(gi));
        end
    endgenerate

    assign wptr_next = push ? ptr_inc(wptr_reg) : wptr_reg;
    assign rptr_next = pop  ? ptr_inc(rptr_reg) : rptr_reg;
    assign err_next  = err_o | (data_r_valid_i & empty) | (pop & ~pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Entry storage carries no reset; stale slots are never read while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_reg] <= {data_ID_i, data_wen_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            data_r_valid_o <= '0;
            data_r_rdata_o <= '0;
            data_r_wen_o   <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            wptr_reg       <= wptr_next;
            rptr_reg       <= rptr_next;
            count_reg      <= count_next;
            data_r_valid_o <= valid_next;
            err_o          <= err_next;
            if (pop_ok) begin
                data_r_rdata_o <= data_r_rdata_i;
                data_r_wen_o   <= pop_wen;
            end
        end
    end

endmodule

// File: tb/tb_resp_router_l2.sv
// Directed bench for resp_router_l2 with a queue-based reference model and
// a scoreboard of expected registered responses.
module tb_resp_router_l2;

    localparam int NM  = 16;
    localparam int DW  = 64;
    localparam int IW  = 5;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_req_i, data_wen_i, data_gnt_i, data_r_valid_i;
    logic [IW-1:0] data_ID_i;
    logic [DW-1:0] data_r_rdata_i;
    logic          data_gnt_o, data_r_wen_o, err_o;
    logic [NM-1:0] data_r_valid_o;
    logic [DW-1:0] data_r_rdata_o;

    resp_router_l2 #(
        .N_MASTER(NM), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_wen_i(data_wen_i), .data_ID_i(data_ID_i),
        .data_gnt_i(data_gnt_i), .data_gnt_o(data_gnt_o),
        .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i),
        .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
        .data_r_wen_o(data_r_wen_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          wen;
    } ent_t;

    typedef struct packed {
        logic [NM-1:0] v;
        logic [DW-1:0] d;
        logic          w;
        logic          e;
    } exp_t;

    ent_t    mfifo[$];
    exp_t    sb[$];
    logic [DW-1:0] hold_d;
    logic    hold_w;
    logic    m_err;
    int      n_cmp = 0;
    int      n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic req, input logic wen, input logic [IW-1:0] id,
                        input logic gnt, input logic rv, input logic [DW-1:0] rd);
        exp_t e;
        ent_t p;
        logic exp_gnt;
        data_req_i = req; data_wen_i = wen; data_ID_i = id;
        data_gnt_i = gnt; data_r_valid_i = rv; data_r_rdata_i = rd;
        #1;
        exp_gnt = gnt && (mfifo.size() != MAX);
        check("gnt_o", 64'(data_gnt_o), 64'(exp_gnt));
        e.v = '0;
        if (rv) begin
            if (mfifo.size() == 0) begin
                m_err = 1'b1;
            end else begin
                p = mfifo.pop_front();
                if (p.id < NM) begin
                    e.v    = NM'(1) << p.id;
                    hold_d = rd;
                    hold_w = p.wen;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (req && exp_gnt) mfifo.push_back({id, wen});
        e.d = hold_d; e.w = hold_w; e.e = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("r_valid_o", 64'(data_r_valid_o), 64'(e.v));
        check("r_rdata_o", data_r_rdata_o, e.d);
        check("r_wen_o", 64'(data_r_wen_o), 64'(e.w));
        check("err_o", 64'(err_o), 64'(e.e));
        $display("step req=%0b id=%0d gnt=%0b rv=%0b -> valid=%h err=%0b",
                 req, id, gnt, rv, data_r_valid_o, err_o);
        data_req_i = 1'b0; data_r_valid_i = 1'b0;
    endtask

    task automatic model_reset();
        mfifo.delete();
        sb.delete();
        hold_d = '0;
        hold_w = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] ids [10];
        ids = '{3, 7, 0, 15, 9, 2, 11, 6, 14, 1};
        rst_n = 1'b0;
        data_req_i = 0; data_wen_i = 0; data_ID_i = '0; data_gnt_i = 0;
        data_r_valid_i = 0; data_r_rdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(data_r_valid_o), 64'h0);
        check("rst_rdata", data_r_rdata_o, 64'h0);
        check("rst_wen", 64'(data_r_wen_o), 64'h0);
        check("rst_err", 64'(err_o), 64'h0);
        check("rst_gnt0", 64'(data_gnt_o), 64'h0);
        data_gnt_i = 1'b1;
        #1;
        check("rst_gnt1", 64'(data_gnt_o), 64'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read to master 5
        step(1, 1, 5, 1, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 0, 1, 1, 64'hDEAD_BEEF);
        check("single_valid", 64'(data_r_valid_o), 64'h0020);
        check("single_rdata", data_r_rdata_o, 64'hDEAD_BEEF);
        check("single_err", 64'(err_o), 64'h0);
        step(0, 0, 0, 1, 0, '0);
        check("single_once", 64'(data_r_valid_o), 64'h0);

        // Fill to capacity; fifth request must be refused
        for (int i = 0; i < 5; i++) step(1, i[0], IW'(i), 1, 0, '0);
        // Pop while full: grant stays low this cycle, then reopens
        step(1, 0, 4, 1, 1, {$urandom, $urandom});
        step(1, 0, 4, 1, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, {$urandom, $urandom});

        // Ordering across pointer wrap
        for (int k = 0; k < 10; k++)
            step(1, k[1], ids[k], 1, (mfifo.size() >= 2), {$urandom, $urandom});
        for (int j = 0; j < 8; j++)
            if (mfifo.size() > 0) step(0, 0, 0, 1, 1, {$urandom, $urandom});

        // Simultaneous push/pop at count 2
        step(1, 1, 3, 1, 0, '0);
        step(1, 0, 9, 1, 0, '0);
        step(1, 1, 12, 1, 1, 64'h1234_5678_9ABC_DEF0);
        check("simul_oldest", 64'(data_r_valid_o), 64'h0008);
        step(0, 0, 0, 1, 1, 64'h5555);
        check("simul_next", 64'(data_r_valid_o), 64'h0200);
        step(0, 0, 0, 1, 1, 64'hAAAA);
        check("simul_last", 64'(data_r_valid_o), 64'h1000);

        // Out-of-range master ID
        step(1, 1, 20, 1, 0, '0);
        step(0, 0, 0, 1, 1, 64'hBAD);
        check("oor_valid", 64'(data_r_valid_o), 64'h0);
        check("oor_err", 64'(err_o), 64'h1);

        // Asynchronous reset with entries outstanding
        step(1, 1, 1, 1, 0, '0);
        step(1, 1, 2, 1, 0, '0);
        step(1, 1, 3, 1, 0, '0);
        data_gnt_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(data_r_valid_o), 64'h0);
        check("arst_rdata", data_r_rdata_o, 64'h0);
        check("arst_wen", 64'(data_r_wen_o), 64'h0);
        check("arst_err", 64'(err_o), 64'h0);
        check("arst_gnt", 64'(data_gnt_o), 64'h1);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Response after reset is a pop-while-empty error
        step(0, 0, 0, 1, 1, 64'h77);
        check("empty_valid", 64'(data_r_valid_o), 64'h0);
        check("empty_err", 64'(err_o), 64'h1);
        step(1, 1, 6, 0, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        check("err_sticky", 64'(err_o), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/resp_router_l2.md
# resp_router_l2

Response-side companion to the L2 request arbitration tree. It sits between the tree's single output port and one L2 memory bank. It records the master ID of every accepted request in an in-order outstanding FIFO. When the bank returns a response, it routes a registered one-hot valid pulse and the read data back to the originating master. It also throttles the grant seen by the tree so outstanding requests never exceed the FIFO capacity.

## Interface
- N_MASTER, 16: number of masters behind the arbitration tree (≥2).
- DATA_WIDTH, 64: read data width.
- ID_WIDTH, 4: width of the binary master index carried on the request ID (≥ $clog2(N_MASTER)).
- MAX_OUTSTANDING, 4: FIFO depth in entries (≥1, any integer, not necessarily a power of two).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- data_req_i  in  1  request valid from tree output.
- data_wen_i  in  1  request write-enable from tree output (1 = read, 0 = write).
- data_ID_i  in  ID_WIDTH  binary master index of the request.
- data_gnt_i  in  1  grant from the memory bank.
- data_gnt_o  out  1  grant to the tree, equal to data_gnt_i & ~full; combinational.
- data_r_valid_i  in  1  bank response valid, one per accepted request, in order.
- data_r_rdata_i  in  DATA_WIDTH  bank response data.
- data_r_valid_o  out  N_MASTER  registered one-hot response valid per master.
- data_r_rdata_o  out  DATA_WIDTH  registered response data, broadcast to all masters.
- data_r_wen_o  out  1  registered wen of the retired request.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Push: when data_req_i & data_gnt_o, write {data_ID_i, data_wen_i} at the write pointer; wptr increments, wrapping from MAX_OUTSTANDING-1 to 0.
- Pop: when data_r_valid_i and not empty, read the entry at rptr; rptr increments with the same wrap.
- count: width $clog2(MAX_OUTSTANDING+1).
  - full = (count == MAX_OUTSTANDING).
  - empty = (count == 0).
  - count updates as +1 on push only, −1 on pop only, unchanged on both or neither.
- Full gating: data_gnt_o is 0 whenever full, even if a pop happens in the same cycle. There is no bypass, so capacity is exactly MAX_OUTSTANDING.
- Simultaneous push and pop when empty: the pop is an error (see below). The push still stores its entry. The pop never returns the entry being pushed in the same cycle.
- Valid response: on a valid pop with ID < N_MASTER, the next cycle drives:
  - data_r_valid_o = 1 << ID;
  - data_r_rdata_o = data_r_rdata_i as captured;
  - data_r_wen_o = the stored wen.
- Write responses (wen = 0) also produce a valid pulse. data_r_rdata_o then carries whatever the bank returned.
- Out-of-range ID: a popped ID ≥ N_MASTER consumes the entry, drives data_r_valid_o to all zeros, and sets err_o.
- Pop while empty: data_r_valid_i with an empty FIFO drives no valid, leaves pointers unchanged, and sets err_o.
- err_o stays at 1 until reset.
- data_r_rdata_o and data_r_wen_o hold their last value when no response is produced. data_r_valid_o returns to 0.

## Timing
- Reset values:
  - data_r_valid_o = 0, data_r_rdata_o = 0, data_r_wen_o = 0, err_o = 0;
  - wptr = rptr = count = 0, so data_gnt_o = data_gnt_i after reset.
- Reset mid-operation discards all outstanding entries. Any response arriving afterwards counts as a pop-while-empty error.
- Grant path: zero-cycle combinational (data_gnt_i, count) → data_gnt_o. There is no combinational path from data_req_i.
- Response latency: exactly 1 cycle from data_r_valid_i to data_r_valid_o. Throughput is one response per cycle.
- Back-to-back responses to the same master produce consecutive 1-cycles on the same data_r_valid_o bit.
- A request pushed in cycle t can be popped no earlier than cycle t+1.

## Test plan
- Single read: N_MASTER=16, push ID=5, wen=1 at t0; r_valid_i with rdata=0xDEAD_BEEF at t2 → data_r_valid_o=0x0020 and rdata=0xDEADBEEF at t3 only; err_o=0.
- Fill/full: MAX_OUTSTANDING=4, gnt_i=1, req every cycle with IDs 0,1,2,3,4 → gnt_o=1 for the first four and 0 on the fifth. Popping one at t5 re-enables gnt_o at t6. Hold gnt_i=1 with a pop in the same full cycle → gnt_o stays 0 that cycle.
- Ordering and wrap: 10 requests with IDs 3,7,0,15,… interleaved with pops keeping count ≤ 3 → valid_o one-hot bits follow push order exactly across pointer wrap.
- Simultaneous push/pop at count=2 → count stays 2; the popped ID is the oldest entry.
- Errors:
  - r_valid_i while empty → valid_o = 0, err_o = 1 next cycle, staying 1 for the rest of the test.
  - Separately, push ID=20 with ID_WIDTH=5, N_MASTER=16, then pop → valid_o = 0, err_o = 1.
- Reset mid-operation: 3 entries outstanding, assert rst_n low asynchronously mid-cycle → all outputs 0 immediately and gnt_o follows gnt_i after release. A later r_valid_i sets err_o.
